// File: rtl/mem_access.sv
// MEM pipeline stage: ALU results pass straight through, and loads/stores run a
// req/ack handshake with data memory while stalling the upstream stages.
module mem_access #(
   parameter logic [3:0]  ALUOP_LW = 4'b1010,
   parameter logic [3:0]  ALUOP_SW = 4'b1011,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  mem_wd,
   input  logic        mem_wreg,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_aluop,
   input  logic [9:0]  mem_mem_addr,
   input  logic [31:0] mem_reg2,
   input  logic        of_i,
   input  logic        zf_i,
   output logic        dm_req,
   output logic        dm_we,
   output logic [9:0]  dm_addr,
   output logic [31:0] dm_wdata,
   input  logic [31:0] dm_rdata,
   input  logic        dm_ack,
   output logic        stall_req,
   output logic [4:0]  wb_wd,
   output logic        wb_wreg,
   output logic [31:0] wb_wdata,
   output logic        of_o,
   output logic        zf_o,
   output logic        mem_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state_r;
   logic [7:0]  cnt_r;
   logic [31:0] load_data_r;
   logic        is_load_r;
   logic        is_mem_op_s;

   assign is_mem_op_s = (mem_aluop == ALUOP_LW) || (mem_aluop == ALUOP_SW);

   // Transaction FSM, memory-side registers and the timeout counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 8'd0;
         load_data_r <= 32'd0;
         is_load_r   <= 1'b0;
         dm_req      <= 1'b0;
         dm_we       <= 1'b0;
         dm_addr     <= 10'd0;
         dm_wdata    <= 32'd0;
         mem_err     <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               mem_err <= 1'b0;
               if (is_mem_op_s) begin
                  dm_addr   <= mem_mem_addr;
                  dm_wdata  <= mem_reg2;
                  dm_we     <= (mem_aluop == ALUOP_SW);
                  is_load_r <= (mem_aluop == ALUOP_LW);
                  dm_req    <= 1'b1;
                  cnt_r     <= 8'd0;
                  state_r   <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               cnt_r <= cnt_r + 8'd1;
               // An ack arriving on the final allowed cycle still completes normally.
               if (dm_ack) begin
                  if (is_load_r) begin
                     load_data_r <= dm_rdata;
                  end
                  dm_req  <= 1'b0;
                  state_r <= ST_DONE;
               end else if (cnt_r == CNT_LAST) begin
                  load_data_r <= 32'd0;
                  dm_req      <= 1'b0;
                  mem_err     <= 1'b1;
                  state_r     <= ST_DONE;
               end
            end
            ST_DONE: begin
               mem_err <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               dm_req  <= 1'b0;
               mem_err <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Stall request and MEM/WB-facing outputs, forced to zero during reset.
   always_comb begin
      stall_req = 1'b0;
      wb_wd     = 5'd0;
      wb_wreg   = 1'b0;
      wb_wdata  = 32'd0;
      of_o      = 1'b0;
      zf_o      = 1'b0;
      if (rst) begin
         stall_req = 1'b0;
      end else begin
         of_o  = of_i;
         zf_o  = zf_i;
         wb_wd = mem_wd;
         case (state_r)
            ST_IDLE: begin
               stall_req = is_mem_op_s;
               wb_wreg   = is_mem_op_s ? 1'b0 : mem_wreg;
               wb_wdata  = mem_wdata;
            end
            ST_BUSY: begin
               stall_req = 1'b1;
               wb_wreg   = 1'b0;
               wb_wdata  = mem_wdata;
            end
            ST_DONE: begin
               stall_req = 1'b0;
               wb_wreg   = is_load_r ? mem_wreg : 1'b0;
               wb_wdata  = is_load_r ? load_data_r : mem_wdata;
            end
            default: begin
               stall_req = 1'b0;
               wb_wreg   = 1'b0;
               wb_wdata  = 32'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: passthrough, load/store handshakes, timeout,
// ack-at-limit, reset mid-transaction and back-to-back memory ops.
module tb_mem_access;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_LW  = 4'b1010;
   localparam logic [3:0] OP_SW  = 4'b1011;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  mem_wd;
   logic        mem_wreg;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_aluop;
   logic [9:0]  mem_mem_addr;
   logic [31:0] mem_reg2;
   logic        of_i, zf_i;
   logic        dm_req, dm_we;
   logic [9:0]  dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ack;
   logic        stall_req;
   logic [4:0]  wb_wd;
   logic        wb_wreg;
   logic [31:0] wb_wdata;
   logic        of_o, zf_o, mem_err;

   int total = 0;
   int bad   = 0;
   int stall_n, req_n;

   mem_access #(.ALUOP_LW(OP_LW), .ALUOP_SW(OP_SW), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
      .of_i(of_i), .zf_i(zf_i),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ack(dm_ack),
      .stall_req(stall_req),
      .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
      .of_o(of_o), .zf_o(zf_o), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Drives one memory op from its IDLE cycle until the DONE cycle; the memory
   // acks on request cycle ack_at (0 = never). Returns with inputs settled in DONE.
   task automatic run_txn(input logic [3:0] op, input logic [9:0] addr,
                          input logic [31:0] st, input int ack_at,
                          input logic [31:0] rd, output int s_n, output int r_n);
      mem_aluop    = op;
      mem_mem_addr = addr;
      mem_reg2     = st;
      dm_ack       = 1'b0;
      s_n = 0;
      r_n = 0;
      #1;
      check("req_low_at_start", {31'd0, dm_req}, 32'd0);
      for (int c = 0; c < 40; c++) begin
         if (!stall_req) break;
         s_n++;
         if (dm_req) begin
            r_n++;
            check("dm_addr", {22'd0, dm_addr}, {22'd0, addr});
            check("dm_wdata", dm_wdata, st);
            check("dm_we", {31'd0, dm_we}, {31'd0, (op == OP_SW)});
         end
         dm_ack   = (ack_at != 0) && (r_n == ack_at);
         dm_rdata = dm_ack ? rd : 32'hBAD0_BAD0;
         tick();
         dm_ack = 1'b0;
         #1;
      end
      check("txn_bound", {31'd0, stall_req}, 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      mem_wd = 5'd3; mem_wreg = 1'b1; mem_wdata = 32'h0000_0005;
      mem_aluop = OP_ADD; mem_mem_addr = 10'd0; mem_reg2 = 32'd0;
      of_i = 1'b1; zf_i = 1'b1; dm_rdata = 32'd0; dm_ack = 1'b0;
      tick();
      tick();
      #1;
      check("rst_stall", {31'd0, stall_req}, 32'd0);
      check("rst_wb_wreg", {31'd0, wb_wreg}, 32'd0);
      check("rst_wb_wd", {27'd0, wb_wd}, 32'd0);
      check("rst_wb_wdata", wb_wdata, 32'd0);
      check("rst_of_zf", {30'd0, of_o, zf_o}, 32'd0);
      check("rst_dm_req_err", {30'd0, dm_req, mem_err}, 32'd0);

      // ADD passthrough, with a stray ack that must be ignored in IDLE.
      rst = 1'b0;
      dm_ack = 1'b1;
      #1;
      check("add_wdata", wb_wdata, 32'h0000_0005);
      check("add_wd", {27'd0, wb_wd}, 32'd3);
      check("add_wreg", {31'd0, wb_wreg}, 32'd1);
      check("add_stall", {31'd0, stall_req}, 32'd0);
      check("add_of_zf", {30'd0, of_o, zf_o}, 32'd3);
      tick();
      dm_ack = 1'b0; of_i = 1'b0;
      #1;
      check("add_no_req", {31'd0, dm_req}, 32'd0);
      check("idle_ack_ignored", {31'd0, stall_req}, 32'd0);
      check("of_follow", {31'd0, of_o}, 32'd0);

      // LW acked on first request cycle.
      mem_wd = 5'd7; mem_wreg = 1'b1; mem_wdata = 32'h0000_0010;
      run_txn(OP_LW, 10'h010, 32'h0000_1111, 1, 32'hDEAD_BEEF, stall_n, req_n);
      check("lw_stall_len", 32'(stall_n), 32'd2);
      check("lw_req_len", 32'(req_n), 32'd1);
      check("lw_wb_wdata", wb_wdata, 32'hDEAD_BEEF);
      check("lw_wb_wreg", {31'd0, wb_wreg}, 32'd1);
      check("lw_wb_wd", {27'd0, wb_wd}, 32'd7);
      check("lw_no_err", {31'd0, mem_err}, 32'd0);
      // Ack during DONE is ignored; the op still on the bus must not restart.
      dm_ack = 1'b1; dm_rdata = 32'h1234_0000;
      tick();
      dm_ack = 1'b0; mem_aluop = OP_ADD;
      #1;
      check("done_ack_ignored", {30'd0, dm_req, stall_req}, 32'd0);

      // SW acked on third request cycle.
      mem_wd = 5'd9; mem_wreg = 1'b1; mem_wdata = 32'h0000_03FF;
      run_txn(OP_SW, 10'h3FF, 32'h1234_5678, 3, 32'h0, stall_n, req_n);
      check("sw_stall_len", 32'(stall_n), 32'd4);
      check("sw_req_len", 32'(req_n), 32'd3);
      check("sw_wb_wreg", {31'd0, wb_wreg}, 32'd0);
      check("sw_wb_wdata", wb_wdata, 32'h0000_03FF);
      tick();
      mem_aluop = OP_ADD;

      // LW with no ack: timeout.
      mem_wd = 5'd4; mem_wreg = 1'b1; mem_wdata = 32'h0000_0020;
      run_txn(OP_LW, 10'h020, 32'h0, 0, 32'h0, stall_n, req_n);
      check("to_stall_len", 32'(stall_n), 32'd17);
      check("to_req_len", 32'(req_n), 32'd16);
      check("to_err", {31'd0, mem_err}, 32'd1);
      check("to_wb_wdata", wb_wdata, 32'd0);
      tick();
      mem_aluop = OP_ADD;
      #1;
      check("to_err_pulse", {31'd0, mem_err}, 32'd0);
      check("to_idle", {30'd0, stall_req, dm_req}, 32'd0);

      // Ack on the very cycle the counter hits its limit: ack wins.
      run_txn(OP_LW, 10'h021, 32'h0, 16, 32'hCAFE_F00D, stall_n, req_n);
      check("lim_req_len", 32'(req_n), 32'd16);
      check("lim_no_err", {31'd0, mem_err}, 32'd0);
      check("lim_wb_wdata", wb_wdata, 32'hCAFE_F00D);
      tick();
      mem_aluop = OP_ADD;

      // Reset during the second BUSY cycle of an LW.
      mem_aluop = OP_LW; mem_mem_addr = 10'h055; mem_wdata = 32'h0000_0042;
      tick();
      tick();
      #1;
      check("rst_busy_req", {31'd0, dm_req}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0; mem_aluop = OP_ADD;
      dm_ack = 1'b1; dm_rdata = 32'hAAAA_5555;
      #1;
      check("rst_busy_req_low", {31'd0, dm_req}, 32'd0);
      check("rst_busy_stall_low", {31'd0, stall_req}, 32'd0);
      tick();
      dm_ack = 1'b0;
      #1;
      check("rst_ack_ignored", wb_wdata, 32'h0000_0042);
      check("rst_no_err", {30'd0, mem_err, dm_req}, 32'd0);

      // Back-to-back LW then SW.
      mem_wd = 5'd12; mem_wreg = 1'b1; mem_wdata = 32'h0000_0100;
      run_txn(OP_LW, 10'h100, 32'h0, 2, 32'h0BAD_CAFE, stall_n, req_n);
      check("b2b_lw_req", 32'(req_n), 32'd2);
      check("b2b_lw_data", wb_wdata, 32'h0BAD_CAFE);
      tick();
      mem_wdata = 32'h0000_0101;
      run_txn(OP_SW, 10'h101, 32'h5555_AAAA, 1, 32'h0, stall_n, req_n);
      check("b2b_sw_req", 32'(req_n), 32'd1);
      check("b2b_sw_stall", 32'(stall_n), 32'd2);
      check("b2b_sw_wreg", {31'd0, wb_wreg}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
